// File: rtl/eqed_inject_ctrl_if.sv
// Handshake/config/observation bundle between an experiment driver and the
// EQED injection controller.
interface eqed_inject_ctrl_if #(
  parameter int NUM_FF = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 10
);
  logic              start;
  logic [SEL_W-1:0]  ff_sel;
  logic [CNT_W-1:0]  inj_cycle;
  logic [NUM_FF-1:0] eqed_sel;
  logic              error_injected;
  logic [CNT_W-1:0]  cycle_count;
  logic              busy;
  logic              done;
  logic              inj_skipped;

  modport master (
    output start, ff_sel, inj_cycle,
    input  eqed_sel, error_injected, cycle_count, busy, done, inj_skipped
  );

  modport slave (
    input  start, ff_sel, inj_cycle,
    output eqed_sel, error_injected, cycle_count, busy, done, inj_skipped
  );
endinterface

// File: rtl/eqed_inject_ctrl.sv
// Run controller for single-bit-flip EQED experiments: one bounded run per
// start, at most one one-hot flip select per run, done pulse at the end.
module eqed_inject_ctrl #(
  parameter int NUM_FF = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 10,
  parameter int WINDOW = 6
) (
  input  logic             clk,
  input  logic             rst,
  eqed_inject_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ff_sel_q, ff_sel_d;
  logic [CNT_W-1:0]  inj_cycle_q, inj_cycle_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic              err_q, err_d;
  logic              skip_q, skip_d;

  logic              ff_valid;
  logic              fire;
  logic [NUM_FF-1:0] eqed_sel;

  // Out-of-range selects are golden runs: never flip, never report a skip.
  assign ff_valid = (ff_sel_q < SEL_W'(NUM_FF));
  assign fire     = (state_q == RUN) && (cycle_count_q == inj_cycle_q) &&
                    ff_valid && !err_q;

  for (genvar gi = 0; gi < NUM_FF; gi++) begin : g_sel
    assign eqed_sel[gi] = fire && (ff_sel_q == SEL_W'(gi));
  end

  always_comb begin
    state_d       = state_q;
    ff_sel_d      = ff_sel_q;
    inj_cycle_d   = inj_cycle_q;
    cycle_count_d = cycle_count_q;
    err_d         = err_q | fire;
    skip_d        = skip_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d       = RUN;
          ff_sel_d      = bus.ff_sel;
          inj_cycle_d   = bus.inj_cycle;
          cycle_count_d = CNT_W'(1);
          err_d         = 1'b0;
          skip_d        = 1'b0;
        end
      end
      RUN: begin
        if (cycle_count_q == WINDOW_C) begin
          state_d = DONE;
          // A flip on the final cycle still counts as applied.
          skip_d  = ff_valid && !err_q && !fire;
        end else begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ff_sel_q      <= '0;
      inj_cycle_q   <= '0;
      cycle_count_q <= '0;
      err_q         <= 1'b0;
      skip_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ff_sel_q      <= ff_sel_d;
      inj_cycle_q   <= inj_cycle_d;
      cycle_count_q <= cycle_count_d;
      err_q         <= err_d;
      skip_q        <= skip_d;
    end
  end

  assign bus.eqed_sel       = eqed_sel;
  assign bus.error_injected = err_q;
  assign bus.cycle_count    = cycle_count_q;
  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.inj_skipped    = skip_q;

endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Directed, table-driven bench for eqed_inject_ctrl plus hand-written
// reset/ignored-start sequences.
module tb_eqed_inject_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  eqed_inject_ctrl_if #(.NUM_FF(8), .SEL_W(4), .CNT_W(10)) bus ();

  eqed_inject_ctrl #(.NUM_FF(8), .SEL_W(4), .CNT_W(10), .WINDOW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       start;
    logic [3:0] ff;
    logic [9:0] inj;
    logic [7:0] eq;
    logic       err;
    logic [9:0] cnt;
    logic       busy;
    logic       done;
    logic       skip;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic s, input logic [3:0] f, input logic [9:0] i,
                             input logic [7:0] e, input logic er, input logic [9:0] c,
                             input logic b, input logic d, input logic sk);
    vec_t r;
    r.start = s; r.ff = f; r.inj = i; r.eq = e; r.err = er;
    r.cnt = c; r.busy = b; r.done = d; r.skip = sk;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e, input logic er,
                         input logic [9:0] c, input logic b, input logic d, input logic sk);
    chk({tag, ".eqed_sel"},       32'(bus.eqed_sel),       32'(e));
    chk({tag, ".error_injected"}, 32'(bus.error_injected), 32'(er));
    chk({tag, ".cycle_count"},    32'(bus.cycle_count),    32'(c));
    chk({tag, ".busy"},           32'(bus.busy),           32'(b));
    chk({tag, ".done"},           32'(bus.done),           32'(d));
    chk({tag, ".inj_skipped"},    32'(bus.inj_skipped),    32'(sk));
    $display("%s: eq=%02h err=%0b cnt=%0d busy=%0b done=%0b skip=%0b", tag,
             bus.eqed_sel, bus.error_injected, bus.cycle_count, bus.busy,
             bus.done, bus.inj_skipped);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b1; bus.ff_sel = 4'd2; bus.inj_cycle = 10'd3;

    // Test 1: reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      step();
      bus.start = i[0]; bus.ff_sel = 4'(i); bus.inj_cycle = 10'(i);
    end
    chk_all("rst_hold", 8'h00, 0, 10'd0, 0, 0, 0);
    rst = 1'b1;
    bus.start = 1'b0;
    step(); step();
    chk_all("rst_released", 8'h00, 0, 10'd0, 0, 0, 0);

    // Test 2: ff_sel=2 inj=3; config churn and start while running are ignored
    vecs.push_back(v(1, 2, 3, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 8'h04, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 1, 4, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 8'h00, 1, 5, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 1, 6, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 1, 6, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 1, 6, 0, 0, 0));
    // Test 3: golden run
    vecs.push_back(v(1, 8, 3, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 8, 3, 8'h00, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 8, 3, 8'h00, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 8, 3, 8'h00, 0, 4, 1, 0, 0));
    vecs.push_back(v(0, 8, 3, 8'h00, 0, 5, 1, 0, 0));
    vecs.push_back(v(0, 8, 3, 8'h00, 0, 6, 1, 0, 0));
    vecs.push_back(v(0, 8, 3, 8'h00, 0, 6, 0, 1, 0));
    vecs.push_back(v(0, 8, 3, 8'h00, 0, 6, 0, 0, 0));
    // Test 4a: inj_cycle beyond window
    vecs.push_back(v(1, 5, 7, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 5, 7, 8'h00, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 5, 7, 8'h00, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 5, 7, 8'h00, 0, 4, 1, 0, 0));
    vecs.push_back(v(0, 5, 7, 8'h00, 0, 5, 1, 0, 0));
    vecs.push_back(v(0, 5, 7, 8'h00, 0, 6, 1, 0, 0));
    vecs.push_back(v(0, 5, 7, 8'h00, 0, 6, 0, 1, 1));
    vecs.push_back(v(0, 5, 7, 8'h00, 0, 6, 0, 0, 1));
    // Test 4b: inj_cycle=0 never matches; skip flag clears at start
    vecs.push_back(v(1, 5, 0, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 5, 0, 8'h00, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 5, 0, 8'h00, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 5, 0, 8'h00, 0, 4, 1, 0, 0));
    vecs.push_back(v(0, 5, 0, 8'h00, 0, 5, 1, 0, 0));
    vecs.push_back(v(0, 5, 0, 8'h00, 0, 6, 1, 0, 0));
    vecs.push_back(v(0, 5, 0, 8'h00, 0, 6, 0, 1, 1));
    vecs.push_back(v(0, 5, 0, 8'h00, 0, 6, 0, 0, 1));
    // Test 6: flip on the last window cycle, then back-to-back golden run
    vecs.push_back(v(1, 7, 6, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 7, 6, 8'h00, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 7, 6, 8'h00, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 7, 6, 8'h00, 0, 4, 1, 0, 0));
    vecs.push_back(v(0, 7, 6, 8'h00, 0, 5, 1, 0, 0));
    vecs.push_back(v(0, 7, 6, 8'h80, 0, 6, 1, 0, 0));
    vecs.push_back(v(0, 7, 6, 8'h00, 1, 6, 0, 1, 0));
    vecs.push_back(v(1, 8, 0, 8'h00, 1, 6, 0, 0, 0));
    vecs.push_back(v(1, 8, 0, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 8, 0, 8'h00, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 8, 0, 8'h00, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 8, 0, 8'h00, 0, 4, 1, 0, 0));
    vecs.push_back(v(0, 8, 0, 8'h00, 0, 5, 1, 0, 0));
    vecs.push_back(v(0, 8, 0, 8'h00, 0, 6, 1, 0, 0));
    vecs.push_back(v(0, 8, 0, 8'h00, 0, 6, 0, 1, 0));
    vecs.push_back(v(0, 8, 0, 8'h00, 0, 6, 0, 0, 0));

    foreach (vecs[k]) begin
      bus.start = vecs[k].start; bus.ff_sel = vecs[k].ff; bus.inj_cycle = vecs[k].inj;
      step();
      chk_all($sformatf("vec%0d", k), vecs[k].eq, vecs[k].err, vecs[k].cnt,
              vecs[k].busy, vecs[k].done, vecs[k].skip);
    end

    // Test 5: restart/config change ignored mid-run, then async reset mid-run
    bus.start = 1'b1; bus.ff_sel = 4'd1; bus.inj_cycle = 10'd2;
    step(); chk_all("t5_c1", 8'h00, 0, 10'd1, 1, 0, 0);
    bus.start = 1'b0;
    step(); chk_all("t5_c2", 8'h02, 0, 10'd2, 1, 0, 0);
    step(); chk_all("t5_c3", 8'h00, 1, 10'd3, 1, 0, 0);
    step(); chk_all("t5_c4", 8'h00, 1, 10'd4, 1, 0, 0);
    bus.start = 1'b1; bus.ff_sel = 4'd6;
    step(); chk_all("t5_c5", 8'h00, 1, 10'd5, 1, 0, 0);
    bus.start = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all("t5_async_rst", 8'h00, 0, 10'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("t5_rst_hold%0d", i), 8'h00, 0, 10'd0, 0, 0, 0);
    end
    rst = 1'b1;

    // Async reset while a flip select is being driven drops it without a clock
    step();
    bus.start = 1'b1; bus.ff_sel = 4'd3; bus.inj_cycle = 10'd1;
    step(); chk_all("t7_flip", 8'h08, 0, 10'd1, 1, 0, 0);
    bus.start = 1'b0;
    #1 rst = 1'b0;
    #1 chk_all("t7_async_rst", 8'h00, 0, 10'd0, 0, 0, 0);
    rst = 1'b1;
    step(); step();
    chk_all("t7_idle", 8'h00, 0, 10'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
